// File: rtl/cmd_interp_fsm.sv
// Command interpreter: collects two decimal operands and an operator from decoder
// pulses, issues one req/ack calculation request, and latches the result.
//
// state   | meaning
// --------+------------------------------------------------------
// ENTER_A | accumulating operand A (or idle after reset/esc)
// ENTER_B | operator latched, accumulating operand B
// EXEC    | calc_req held high, waiting for calc_ack
// RESULT  | result shown on disp_val, may be chained as operand A
module cmd_interp_fsm #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       char_i,
    input  logic             got_dig_i,
    input  logic             got_op_i,
    input  logic             got_eq_i,
    input  logic             got_esc_i,
    output logic             calc_req_o,
    input  logic             calc_ack_i,
    input  logic [WIDTH-1:0] calc_result_i,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic [1:0]       opcode_o,
    output logic [WIDTH-1:0] disp_val_o,
    output logic             err_o
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, RESULT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, disp_q, disp_d;
    logic [1:0]       opcode_q, opcode_d;
    logic             err_q, err_d, req_q, req_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    logic [7:0]       digit_val;
    logic [WIDTH-1:0] digit_w, acc_a, acc_b;
    logic [1:0]       op_map;

    assign digit_val = char_i - 8'h30;
    assign digit_w   = WIDTH'(digit_val[3:0]);
    assign acc_a     = opa_q * WIDTH'(10) + digit_w;
    assign acc_b     = opb_q * WIDTH'(10) + digit_w;

    always_comb begin
        case (char_i)
            8'h2A:   op_map = 2'b10;
            8'h2D:   op_map = 2'b01;
            8'h2F:   op_map = 2'b11;
            default: op_map = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ENTER_A;
            opa_q    <= '0;
            opb_q    <= '0;
            disp_q   <= '0;
            opcode_q <= 2'b00;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            disp_q   <= disp_d;
            opcode_q <= opcode_d;
            err_q    <= err_d;
            req_q    <= req_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        disp_d   = disp_q;
        opcode_d = opcode_q;
        err_d    = err_q;
        req_d    = req_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;

        if (got_esc_i) begin
            state_d  = ENTER_A;
            opa_d    = '0;
            opb_d    = '0;
            disp_d   = '0;
            opcode_d = 2'b00;
            err_d    = 1'b0;
            req_d    = 1'b0;
            cnt_a_d  = '0;
            cnt_b_d  = '0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (!got_eq_i) begin
                        if (got_op_i) begin
                            if (cnt_a_q != '0) begin
                                opcode_d = op_map;
                                opb_d    = '0;
                                cnt_b_d  = '0;
                                disp_d   = '0;
                                state_d  = ENTER_B;
                            end
                        end else if (got_dig_i) begin
                            if (cnt_a_q < CW'(MAX_DIGITS)) begin
                                opa_d   = acc_a;
                                disp_d  = acc_a;
                                cnt_a_d = cnt_a_q + 1'b1;
                                if (cnt_a_q == '0) err_d = 1'b0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                ENTER_B: begin
                    if (got_eq_i) begin
                        if (cnt_b_q != '0) begin
                            // Divide by zero never reaches the arithmetic unit
                            if (opcode_q == 2'b11 && opb_q == '0) begin
                                err_d   = 1'b1;
                                opa_d   = '0;
                                opb_d   = '0;
                                disp_d  = '0;
                                cnt_a_d = '0;
                                cnt_b_d = '0;
                                state_d = ENTER_A;
                            end else begin
                                req_d   = 1'b1;
                                state_d = EXEC;
                            end
                        end
                    end else if (got_op_i) begin
                        if (cnt_b_q == '0) opcode_d = op_map;
                    end else if (got_dig_i) begin
                        if (cnt_b_q < CW'(MAX_DIGITS)) begin
                            opb_d   = acc_b;
                            disp_d  = acc_b;
                            cnt_b_d = cnt_b_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (req_q && calc_ack_i) begin
                        disp_d  = calc_result_i;
                        req_d   = 1'b0;
                        state_d = RESULT;
                    end
                end
                RESULT: begin
                    if (!got_eq_i) begin
                        if (got_op_i) begin
                            opa_d    = disp_q;
                            cnt_a_d  = CW'(1);
                            opb_d    = '0;
                            cnt_b_d  = '0;
                            disp_d   = '0;
                            opcode_d = op_map;
                            state_d  = ENTER_B;
                        end else if (got_dig_i) begin
                            opa_d   = digit_w;
                            disp_d  = digit_w;
                            opb_d   = '0;
                            cnt_a_d = CW'(1);
                            cnt_b_d = '0;
                            err_d   = 1'b0;
                            state_d = ENTER_A;
                        end
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    assign calc_req_o = req_q;
    assign opa_o      = opa_q;
    assign opb_o      = opb_q;
    assign opcode_o   = opcode_q;
    assign disp_val_o = disp_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_cmd_interp_fsm.sv
// Directed bench for cmd_interp_fsm: typed command strings with hand-computed results.
module tb_cmd_interp_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  char_in;
    logic        got_dig, got_op, got_eq, got_esc;
    logic        calc_req, calc_ack;
    logic [15:0] calc_result;
    logic [15:0] opa, opb, disp_val;
    logic [1:0]  opcode;
    logic        err;

    int checks = 0;
    int errors = 0;

    cmd_interp_fsm #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .char_i       (char_in),
        .got_dig_i    (got_dig),
        .got_op_i     (got_op),
        .got_eq_i     (got_eq),
        .got_esc_i    (got_esc),
        .calc_req_o   (calc_req),
        .calc_ack_i   (calc_ack),
        .calc_result_i(calc_result),
        .opa_o        (opa),
        .opb_o        (opb),
        .opcode_o     (opcode),
        .disp_val_o   (disp_val),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle pulse launched and retired on falling edges
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        char_in = c;
        got_dig = (c >= 8'h30 && c <= 8'h39);
        got_op  = (c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F);
        got_eq  = (c == 8'h3D || c == 8'h0D);
        got_esc = (c == 8'h1B);
        @(negedge clk);
        got_dig = 1'b0;
        got_op  = 1'b0;
        got_eq  = 1'b0;
        got_esc = 1'b0;
        char_in = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_ack(input int dly, input logic [15:0] res);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("req_hold", {31'd0, calc_req}, 32'd1);
        end
        calc_ack    = 1'b1;
        calc_result = res;
        @(negedge clk);
        calc_ack    = 1'b0;
        calc_result = 16'd0;
        chk("req_drop", {31'd0, calc_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        char_in = 8'h00;
        got_dig = 1'b0; got_op = 1'b0; got_eq = 1'b0; got_esc = 1'b0;
        calc_ack = 1'b0; calc_result = 16'd0;
        #1;
        chk("rst_req",  {31'd0, calc_req}, 32'd0);
        chk("rst_disp", {16'd0, disp_val}, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: async reset while a request is pending
        send_str("1+1=");
        chk("t1_req_before", {31'd0, calc_req}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_req",    {31'd0, calc_req}, 32'd0);
        chk("t1_opa",    {16'd0, opa}, 32'd0);
        chk("t1_opb",    {16'd0, opb}, 32'd0);
        chk("t1_opcode", {30'd0, opcode}, 32'd0);
        chk("t1_disp",   {16'd0, disp_val}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send("3");
        chk("t1_enter_a", {16'd0, disp_val}, 32'd3);
        send(8'h1B);

        // Test 2: "12+34=" with ack two cycles after req
        send_str("12+3");
        chk("t2_disp_b", {16'd0, disp_val}, 32'd3);
        chk("t2_req_early", {31'd0, calc_req}, 32'd0);
        send_str("4=");
        chk("t2_req",    {31'd0, calc_req}, 32'd1);
        chk("t2_opa",    {16'd0, opa}, 32'd12);
        chk("t2_opb",    {16'd0, opb}, 32'd34);
        chk("t2_opcode", {30'd0, opcode}, 32'd0);
        do_ack(2, 16'd46);
        chk("t2_disp", {16'd0, disp_val}, 32'd46);

        // Test 5 (chaining from result 46)
        send_str("*2=");
        chk("t5_req",    {31'd0, calc_req}, 32'd1);
        chk("t5_opa",    {16'd0, opa}, 32'd46);
        chk("t5_opb",    {16'd0, opb}, 32'd2);
        chk("t5_opcode", {30'd0, opcode}, 32'd2);
        do_ack(1, 16'd92);
        chk("t5_disp", {16'd0, disp_val}, 32'd92);
        send("9");
        chk("t5_new_opa",  {16'd0, opa}, 32'd9);
        chk("t5_new_opb",  {16'd0, opb}, 32'd0);
        chk("t5_new_disp", {16'd0, disp_val}, 32'd9);
        send("3");
        chk("t5_accum_a", {16'd0, disp_val}, 32'd93);
        send(8'h1B);

        // Test 3: divide by zero
        send_str("7/0=");
        chk("t3_err",  {31'd0, err}, 32'd1);
        chk("t3_req",  {31'd0, calc_req}, 32'd0);
        chk("t3_disp", {16'd0, disp_val}, 32'd0);
        chk("t3_opa",  {16'd0, opa}, 32'd0);
        @(negedge clk);
        chk("t3_req_later", {31'd0, calc_req}, 32'd0);
        send("5");
        chk("t3_err_clr", {31'd0, err}, 32'd0);
        chk("t3_disp5",   {16'd0, disp_val}, 32'd5);
        send(8'h1B);
        chk("t3_esc_disp", {16'd0, disp_val}, 32'd0);

        // Test 4: digit overflow and operator replacement
        send_str("1234");
        chk("t4_err_4dig", {31'd0, err}, 32'd0);
        send("5");
        chk("t4_disp", {16'd0, disp_val}, 32'd1234);
        chk("t4_err",  {31'd0, err}, 32'd1);
        send_str("+-2=");
        chk("t4_opcode", {30'd0, opcode}, 32'd1);
        chk("t4_opb",    {16'd0, opb}, 32'd2);
        chk("t4_opa",    {16'd0, opa}, 32'd1234);
        chk("t4_req",    {31'd0, calc_req}, 32'd1);
        do_ack(0, 16'd1232);
        chk("t4_result", {16'd0, disp_val}, 32'd1232);
        send(8'h1B);

        // Ignored op with no A digits, ignored eq with no B digits
        send_str("*5+=");
        chk("ign_req",    {31'd0, calc_req}, 32'd0);
        chk("ign_opcode", {30'd0, opcode}, 32'd0);
        send_str("6=");
        chk("ign_req2", {31'd0, calc_req}, 32'd1);
        chk("ign_opb",  {16'd0, opb}, 32'd6);

        // Test 6: esc during EXEC, then a stray ack
        send(8'h1B);
        chk("t6_req",  {31'd0, calc_req}, 32'd0);
        chk("t6_disp", {16'd0, disp_val}, 32'd0);
        chk("t6_opa",  {16'd0, opa}, 32'd0);
        @(negedge clk);
        calc_ack = 1'b1;
        calc_result = 16'd11;
        @(negedge clk);
        calc_ack = 1'b0;
        calc_result = 16'd0;
        chk("t6_ack_req",  {31'd0, calc_req}, 32'd0);
        chk("t6_ack_disp", {16'd0, disp_val}, 32'd0);
        send("8");
        chk("t6_enter_a", {16'd0, disp_val}, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
